// File: rtl/btn_cond_pkg.sv
// Shared constants for the button conditioner: default timing values and channel indices.
package btn_cond_pkg;

    localparam int unsigned BTN_DB_CYCLES_50M = 250000;  // 5 ms at 50 MHz
    localparam int unsigned BTN_DAS_TICKS     = 20;
    localparam int unsigned BTN_ARR_TICKS     = 5;

    localparam int unsigned BTN_ROT   = 0;
    localparam int unsigned BTN_LEFT  = 1;
    localparam int unsigned BTN_RIGHT = 2;
    localparam int unsigned BTN_N_CH  = 3;

endpackage

// File: rtl/btn_channel.sv
// One button channel: polarity fix, 2-FF sync, debounce, press edge, optional hold-to-repeat
// (built only with BTN_AUTOREPEAT_EN), and the tick-aligned pending/act path.
module btn_channel
    import btn_cond_pkg::*;
#(
    parameter int unsigned DB_CYCLES = BTN_DB_CYCLES_50M,
    parameter bit          INVERT    = 1'b1,
    parameter bit          REPEAT    = 1'b0,
    parameter int unsigned DAS_TICKS = BTN_DAS_TICKS,
    parameter int unsigned ARR_TICKS = BTN_ARR_TICKS
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_raw,
    input  logic i_tick,
    output logic o_level,
    output logic o_act,
    output logic o_collapsed
);

    localparam int unsigned DbW = $clog2(DB_CYCLES + 1);

    logic [1:0]     r_sync;
    logic [DbW-1:0] r_db_cnt;
    logic [DbW-1:0] w_db_cnt_d;
    logic           r_level;
    logic           w_level_d;
    logic           r_level_q;
    logic           r_pending;
    logic           r_act;
    logic           r_collapsed;

    logic w_sync;
    logic w_press;
    logic w_rpt;
    logic w_evt;
    logic w_busy;

    assign w_sync = r_sync[1];

    // Level only flips after the synchronized input has disagreed for DB_CYCLES cycles in a row.
    always_comb begin
        w_db_cnt_d = '0;
        w_level_d  = r_level;
        if (w_sync != r_level) begin
            if (r_db_cnt == DbW'(DB_CYCLES - 1)) begin
                w_level_d = ~r_level;
            end else begin
                w_db_cnt_d = r_db_cnt + DbW'(1);
            end
        end
    end

    assign w_press = r_level & ~r_level_q;

`ifdef BTN_AUTOREPEAT_EN
    if (REPEAT) begin : g_hold
        localparam int unsigned HoldW = $clog2(DAS_TICKS + 1);

        logic [HoldW-1:0] r_hold;
        logic [HoldW-1:0] w_hold_d;
        logic             w_hit;

        // The tick that serves the initial press does not count toward the hold time.
        always_comb begin
            w_hold_d = r_hold;
            w_hit    = 1'b0;
            if (!r_level) begin
                w_hold_d = '0;
            end else if (i_tick && !(r_pending || w_press)) begin
                if (r_hold == HoldW'(DAS_TICKS - 1)) begin
                    w_hit    = 1'b1;
                    w_hold_d = HoldW'(DAS_TICKS - ARR_TICKS);
                end else begin
                    w_hold_d = r_hold + HoldW'(1);
                end
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_hold <= '0;
            end else begin
                r_hold <= w_hold_d;
            end
        end

        assign w_rpt = w_hit;
    end else begin : g_no_hold
        assign w_rpt = 1'b0;
    end
`else
    assign w_rpt = 1'b0;
`endif

    assign w_evt  = w_press | w_rpt;
    assign w_busy = r_pending | w_evt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync      <= '0;
            r_db_cnt    <= '0;
            r_level     <= 1'b0;
            r_level_q   <= 1'b0;
            r_pending   <= 1'b0;
            r_act       <= 1'b0;
            r_collapsed <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], i_btn_raw ^ INVERT};
            r_db_cnt    <= w_db_cnt_d;
            r_level     <= w_level_d;
            r_level_q   <= r_level;
            r_pending   <= w_busy & ~i_tick;
            r_act       <= w_busy & i_tick;
            r_collapsed <= w_evt & r_pending & ~i_tick;
        end
    end

    assign o_level     = r_level;
    assign o_act       = r_act;
    assign o_collapsed = r_collapsed;

endmodule

// File: rtl/btn_conditioner_n.sv
// N-channel button conditioner: one btn_channel per button, all sharing the frame tick.
// Hold-to-repeat is built only when BTN_AUTOREPEAT_EN is defined.
module btn_conditioner_n
    import btn_cond_pkg::*;
#(
    parameter int unsigned     N_CH        = BTN_N_CH,
    parameter int unsigned     DB_CYCLES   = BTN_DB_CYCLES_50M,
    parameter logic [N_CH-1:0] INVERT_MASK = {N_CH{1'b1}},
    parameter logic [N_CH-1:0] REPEAT_MASK = N_CH'(3'b110),
    parameter int unsigned     DAS_TICKS   = BTN_DAS_TICKS,
    parameter int unsigned     ARR_TICKS   = BTN_ARR_TICKS
) (
    input  logic            CLOCK_50,
    input  logic            resetn,
    input  logic [N_CH-1:0] btn_raw,
    input  logic            tick_input,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] act,
    output logic [N_CH-1:0] collapsed
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_channel #(
            .DB_CYCLES (DB_CYCLES),
            .INVERT    (INVERT_MASK[i]),
            .REPEAT    (REPEAT_MASK[i]),
            .DAS_TICKS (DAS_TICKS),
            .ARR_TICKS (ARR_TICKS)
        ) u_channel (
            .i_clk       (CLOCK_50),
            .i_rst_n     (resetn),
            .i_btn_raw   (btn_raw[i]),
            .i_tick      (tick_input),
            .o_level     (level[i]),
            .o_act       (act[i]),
            .o_collapsed (collapsed[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner_n.sv
// Bench for btn_conditioner_n: a cycle model pushes expected outputs per driven cycle into a
// scoreboard; a negedge monitor pops and compares. Directed checks cover the key scenarios.
module tb_btn_conditioner_n;

    localparam int unsigned NCh = 3;
    localparam int unsigned Db  = 8;
    localparam int unsigned Das = 4;
    localparam int unsigned Arr = 2;
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [2:0] Rep     = 3'b110;
    localparam int         ExpHold = 5;
`else
    localparam logic [2:0] Rep     = 3'b000;
    localparam int         ExpHold = 1;
`endif

    logic           clk;
    logic           resetn;
    logic [NCh-1:0] btn_raw;
    logic           tick_input;
    logic [NCh-1:0] level;
    logic [NCh-1:0] act;
    logic [NCh-1:0] collapsed;

    btn_conditioner_n #(
        .N_CH        (NCh),
        .DB_CYCLES   (Db),
        .INVERT_MASK (3'b111),
        .REPEAT_MASK (3'b110),
        .DAS_TICKS   (Das),
        .ARR_TICKS   (Arr)
    ) u_dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .btn_raw    (btn_raw),
        .tick_input (tick_input),
        .level      (level),
        .act        (act),
        .collapsed  (collapsed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    typedef struct {
        int unsigned cyc;
        logic [2:0]  lvl;
        logic [2:0]  act;
        logic [2:0]  col;
    } exp_t;
    exp_t sb_q[$];

    // Model state: streak counts consecutive cycles the synced input disagreed with level;
    // held counts ticks seen while held after the press was served.
    bit m_s1[NCh], m_s2[NCh], m_lvl[NCh], m_lvlq[NCh], m_pend[NCh], m_act[NCh], m_col[NCh];
    int m_streak[NCh], m_held[NCh];

    int act_cnt[NCh];
    int col_cnt[NCh];
    int lvl_cnt[NCh];

    initial begin
        for (int i = 0; i < NCh; i++) begin
            act_cnt[i] = 0;
            col_cnt[i] = 0;
            lvl_cnt[i] = 0;
        end
        forever begin
            exp_t e;
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                e = sb_q.pop_front();
                chk("level", int'(level), int'(e.lvl));
                chk("act", int'(act), int'(e.act));
                chk("collapsed", int'(collapsed), int'(e.col));
            end
            for (int i = 0; i < NCh; i++) begin
                if (act[i]) act_cnt[i]++;
                if (collapsed[i]) col_cnt[i]++;
                if (level[i]) lvl_cnt[i]++;
            end
        end
    end

    task automatic model_step(input logic [2:0] raw, input logic tick, input logic rstn);
        exp_t e;
        for (int i = 0; i < NCh; i++) begin
            if (!rstn) begin
                m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_lvlq[i] = 0;
                m_pend[i] = 0; m_act[i] = 0; m_col[i] = 0; m_streak[i] = 0; m_held[i] = 0;
            end else begin
                bit press, rpt, evt, nlvl;
                press = m_lvl[i] && !m_lvlq[i];
                rpt   = 0;
                if (!m_lvl[i]) begin
                    m_held[i] = 0;
                end else if (tick && Rep[i] && !(m_pend[i] || press)) begin
                    m_held[i]++;
                    if (m_held[i] == Das || (m_held[i] > Das && (m_held[i] - Das) % Arr == 0))
                        rpt = 1;
                end
                evt      = press || rpt;
                m_act[i] = tick && (m_pend[i] || evt);
                m_col[i] = evt && m_pend[i] && !tick;
                m_pend[i] = (m_pend[i] || evt) && !tick;
                nlvl = m_lvl[i];
                if (m_s2[i] != m_lvl[i]) begin
                    m_streak[i]++;
                    if (m_streak[i] == Db) begin
                        nlvl = !m_lvl[i];
                        m_streak[i] = 0;
                    end
                end else begin
                    m_streak[i] = 0;
                end
                m_lvlq[i] = m_lvl[i];
                m_lvl[i]  = nlvl;
                m_s2[i]   = m_s1[i];
                m_s1[i]   = !raw[i];
            end
        end
        e.cyc = cyc + 1;
        for (int i = 0; i < NCh; i++) begin
            e.lvl[i] = m_lvl[i];
            e.act[i] = m_act[i];
            e.col[i] = m_col[i];
        end
        sb_q.push_back(e);
    endtask

    // Drive one cycle of inputs just after a negedge; return just after the next negedge.
    task automatic step(input logic [2:0] raw, input logic tick, input logic rstn);
        btn_raw    = raw;
        tick_input = tick;
        resetn     = rstn;
        model_step(raw, tick, rstn);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic [2:0] raw, input int period);
        for (int k = 0; k < n; k++) begin
            step(raw, (period > 0) && (k % period == period - 1), 1'b1);
        end
    endtask

    int a0[NCh];
    int c0[NCh];
    int l0[NCh];

    task automatic snap();
        for (int i = 0; i < NCh; i++) begin
            a0[i] = act_cnt[i];
            c0[i] = col_cnt[i];
            l0[i] = lvl_cnt[i];
        end
    endtask

    initial begin
        for (int i = 0; i < NCh; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_lvlq[i] = 0;
            m_pend[i] = 0; m_act[i] = 0; m_col[i] = 0; m_streak[i] = 0; m_held[i] = 0;
        end
        resetn     = 1'b0;
        btn_raw    = 3'b111;
        tick_input = 1'b0;
        #1;
        chk("reset_level", int'(level), 0);
        chk("reset_act", int'(act), 0);
        chk("reset_collapsed", int'(collapsed), 0);
        @(negedge clk);
        #1;
        run(6, 3'b111, 0);

        // Clean press on channel 1, tick every 20 cycles.
        snap();
        for (int k = 0; k < 21; k++) begin
            step(3'b101, k == 19, 1'b1);
            if (k == 8) chk("s1_level_before", int'(level[1]), 0);
            if (k == 9) chk("s1_level_rise", int'(level[1]), 1);
            if (k == 19) chk("s1_act_pulse", int'(act[1]), 1);
            if (k == 20) chk("s1_act_one_cycle", int'(act[1]), 0);
        end
        run(20, 3'b111, 20);
        chk("s1_act_count", act_cnt[1] - a0[1], 1);

        // Bounce on channel 0 shorter than the debounce window.
        snap();
        for (int k = 0; k < 40; k++) begin
            step({2'b11, 1'(((k / 5) % 2) != 0)}, (k % 7) == 6, 1'b1);
        end
        run(20, 3'b111, 7);
        chk("bounce_level", lvl_cnt[0] - l0[0], 0);
        chk("bounce_act", act_cnt[0] - a0[0], 0);

        // Two presses on channel 2 with no tick in between collapse into one action.
        snap();
        run(14, 3'b011, 0);
        run(14, 3'b111, 0);
        run(14, 3'b011, 0);
        run(14, 3'b111, 0);
        chk("collapse_count", col_cnt[2] - c0[2], 1);
        chk("collapse_no_act_yet", act_cnt[2] - a0[2], 0);
        run(8, 3'b111, 8);
        chk("collapse_act_count", act_cnt[2] - a0[2], 1);

        // All three held for 12 ticks: repeat channels re-fire, channel 0 fires once.
        snap();
        run(10, 3'b000, 0);
        run(48, 3'b000, 4);
        run(14, 3'b111, 0);
        chk("hold_rot_acts", act_cnt[0] - a0[0], 1);
        chk("hold_left_acts", act_cnt[1] - a0[1], ExpHold);
        chk("hold_right_acts", act_cnt[2] - a0[2], ExpHold);

        // Press edge coincident with a tick is served immediately and leaves nothing pending.
        for (int k = 0; k < 12; k++) begin
            step(3'b110, (k == 10) || (k == 11), 1'b1);
            if (k == 9) chk("coinc_no_act_early", int'(act[0]), 0);
            if (k == 10) chk("coinc_act", int'(act[0]), 1);
            if (k == 11) chk("coinc_not_pending", int'(act[0]), 0);
        end
        run(20, 3'b111, 0);

        // Reset while an action is pending discards it.
        run(14, 3'b101, 0);
        chk("pre_reset_level", int'(level[1]), 1);
        snap();
        resetn = 1'b0;
        #1;
        chk("midreset_level", int'(level), 0);
        chk("midreset_act", int'(act), 0);
        chk("midreset_collapsed", int'(collapsed), 0);
        for (int k = 0; k < 3; k++) step(3'b111, 1'b0, 1'b0);
        run(30, 3'b111, 5);
        chk("post_reset_acts", act_cnt[1] - a0[1], 0);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/btn_conditioner_n.md
# btn_conditioner_n

N-channel button conditioner that turns raw, bouncy, active-low KEY inputs into clean, one-shot action pulses for the game FSM. Each action pulse is re-timed to the input frame tick, and at most one action per channel is issued per frame. It generalises the per-button synchronize → debounce → edge-detect → pending chain to a parametrised channel count with per-channel polarity. It adds optional hold-to-repeat (delayed auto shift), which the single-shot chain lacks. It sits between the board KEYs plus `tick_i`, and the game logic.

## Interface
- `N_CH`, 3: number of button channels.
- `DB_CYCLES`, 250000: cycles of stable synchronized input required to change the debounced level (5 ms at 50 MHz); ≥1.
- `INVERT_MASK`, {N_CH{1'b1}}: bit i=1 means channel i is active-low.
- `REPEAT_MASK`, 3'b110: bit i=1 enables auto-repeat on channel i. Rotate (bit 0) does not repeat.
- `DAS_TICKS`, 20: tick_input periods of hold before the first repeat; ≥1.
- `ARR_TICKS`, 5: tick_input periods between subsequent repeats; 1 ≤ ARR_TICKS ≤ DAS_TICKS.
- `CLOCK_50  in  1`: the single clock; all state is on its rising edge.
- `resetn  in  1`: asynchronous, active-low reset.
- `btn_raw  in  N_CH`: raw asynchronous button inputs.
- `tick_input  in  1`: frame strobe, one cycle high per frame.
- `level  out  N_CH`: debounced pressed level (1 = pressed).
- `act  out  N_CH`: one-cycle action pulse per channel.
- `collapsed  out  N_CH`: one-cycle pulse when an event is merged into an already-pending action.

## Operation
- Per channel, in order:
  - XOR with `INVERT_MASK[i]`.
  - 2-FF synchronizer; both flops reset to 0 (released).
  - Debounce counter, `$clog2(DB_CYCLES+1)` bits. It increments while sync ≠ level and clears to 0 whenever sync = level. When it reaches DB_CYCLES-1 with sync ≠ level, level toggles and the counter clears.
- Press event = level & ~level_q (level rising; falling edges generate nothing).
- Pending flag:
  - next = (pending | evt) & ~tick_input.
  - act (registered) next = tick_input & (pending | evt).
  - An event in the same cycle as tick_input is served by that tick.
- `collapsed` pulses when evt=1, pending=1 and tick_input=0.
- Auto-repeat (macro enabled, `REPEAT_MASK[i]`=1):
  - Hold counter, `$clog2(DAS_TICKS+1)` bits, clears while level=0 and increments on each tick_input while level=1.
  - When it equals DAS_TICKS-1 on a tick_input cycle, a repeat event is raised in that cycle and the counter loads DAS_TICKS-ARR_TICKS.
  - A repeat event feeds the same pending/act path as a press event.
- Release (level falling) clears the hold counter. An action already pending is still delivered on the next tick.
- Channels are fully independent; simultaneous events on several channels each produce their own act.

## Timing
- Reset values: level=0, act=0, collapsed=0. Synchronizers, counters, pending and level_q all reset to 0.
- Raw edge stable from cycle 0: sync output changes at cycle 2, and level changes at cycle 2+DB_CYCLES.
- act rises the cycle after the first tick_input at or after the level rise, and stays high for exactly 1 cycle.
- Repeats:
  - The first repeat act follows the DAS_TICKS-th tick after the press tick.
  - Later repeat acts are spaced every ARR_TICKS ticks.
- A bounce shorter than DB_CYCLES cycles produces no level change and no act.
- resetn asserted mid-operation clears all state immediately. Presses in flight are discarded, and a button held through reset release produces a fresh press DB_CYCLES+2 cycles later.
- tick_input held high for k cycles behaves as k ticks.

## Configuration
- `BTN_AUTOREPEAT_EN`
  - Defined: hold counters and repeat events are built for channels with `REPEAT_MASK` set.
  - Undefined: no hold counters. Each press yields exactly one act regardless of hold time; `DAS_TICKS`, `ARR_TICKS` and `REPEAT_MASK` are ignored.

## Structure
- Package `btn_cond_pkg` holds:
  - default constants (`BTN_DB_CYCLES_50M`, `BTN_DAS_TICKS`, `BTN_ARR_TICKS`);
  - channel index constants (`BTN_ROT`=0, `BTN_LEFT`=1, `BTN_RIGHT`=2).
- Sub-module `btn_channel` implements one channel (sync, debounce, edge, hold, pending). The top instantiates N_CH copies in a generate loop.

## Test plan
- DB_CYCLES=8; channel 1 raw goes low at cycle 0; tick every 20 cycles → level[1]=1 at cycle 10, and act[1] is one cycle high the cycle after the next tick.
- Raw toggles every 5 cycles for 40 cycles, then settles released → level stays 0, act stays 0.
- Two presses (release in between) with no tick between them → one act, and collapsed pulses once.
- Macro on, DAS_TICKS=4, ARR_TICKS=2, channel 2 held for 12 ticks → acts after ticks 0, 4, 6, 8, 10. Channel 0 held the same way → a single act. Macro off → a single act on every channel.
- Press event coincident with tick_input → act the next cycle; pending is 0 afterwards.
- resetn pulsed low while pending=1 → no act after reset release; all outputs read 0 during reset.
